// File: rtl/free_list_param.sv
// Physical-register free list for the rename stage: a circular FIFO of free PR numbers
// with all-or-nothing multi-lane allocation, masked multi-lane frees and head checkpoint restore.
module free_list_param #(
    parameter int unsigned NUM_PR     = 64,
    parameter int unsigned NUM_ARCH   = 16,
    parameter int unsigned ALLOC_WAYS = 4,
    parameter int unsigned FREE_WAYS  = 4,
    localparam int unsigned PTR_W     = $clog2(NUM_PR)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [ALLOC_WAYS-1:0]         alloc_req,
    output logic                          alloc_gnt,
    output logic [ALLOC_WAYS*PTR_W-1:0]   alloc_pr,
    input  logic [FREE_WAYS-1:0]          free_vld,
    input  logic [FREE_WAYS*PTR_W-1:0]    free_pr,
    input  logic                          flush,
    input  logic [PTR_W:0]                flush_ptr,
    output logic [PTR_W:0]                head_ptr,
    output logic [PTR_W:0]                free_cnt,
    output logic                          empty,
    output logic                          low,
    output logic                          overflow_err
);

    localparam int unsigned CW = PTR_W + 1;
    localparam int unsigned WW = PTR_W + 3;

    logic [PTR_W-1:0] list_q [NUM_PR];
    logic [CW-1:0]    head_q, head_d;
    logic [CW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [WW-1:0]    req_n;
    logic [WW-1:0]    free_m;
    logic [WW-1:0]    gnt_n;
    logic [WW-1:0]    cnt_sum;
    logic             gnt;
    logic             ovf_now;
    logic [CW-1:0]    rd_off;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    wr_off;
    logic [CW-1:0]    wr_ptr;
    logic [PTR_W-1:0] wr_idx [FREE_WAYS];

    always_comb begin
        req_n = '0;
        for (int unsigned i = 0; i < ALLOC_WAYS; i++) begin
            req_n = req_n + WW'(alloc_req[i]);
        end
        free_m = '0;
        for (int unsigned j = 0; j < FREE_WAYS; j++) begin
            free_m = free_m + WW'(free_vld[j]);
        end
    end

    // Grant compares against the registered count, so same-cycle frees are not bypassed.
    assign gnt = (req_n != '0) && (req_n <= WW'(cnt_q)) && !stall && !flush && !rst;

    always_comb begin
        rd_off   = '0;
        rd_ptr   = '0;
        alloc_pr = '0;
        for (int unsigned i = 0; i < ALLOC_WAYS; i++) begin
            rd_ptr = head_q + rd_off;
            if (gnt && alloc_req[i]) begin
                alloc_pr[i*PTR_W +: PTR_W] = list_q[rd_ptr[PTR_W-1:0]];
            end
            if (alloc_req[i]) begin
                rd_off = rd_off + CW'(1);
            end
        end
    end

    always_comb begin
        wr_off = '0;
        wr_ptr = '0;
        for (int unsigned j = 0; j < FREE_WAYS; j++) begin
            wr_ptr    = tail_q + wr_off;
            wr_idx[j] = wr_ptr[PTR_W-1:0];
            if (free_vld[j]) begin
                wr_off = wr_off + CW'(1);
            end
        end
    end

    always_comb begin
        gnt_n   = gnt ? req_n : '0;
        cnt_sum = WW'(cnt_q) - gnt_n + free_m;
        ovf_now = cnt_sum > WW'(NUM_PR);
        ovf_d   = ovf_q | ovf_now;
        tail_d  = ovf_now ? tail_q : tail_q + CW'(free_m);
        if (flush) begin
            head_d = flush_ptr;
        end else begin
            head_d = head_q + CW'(gnt_n);
        end
        // Count always equals tail - head, which also covers the flush recompute.
        cnt_d   = tail_d - head_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PR; i++) begin
                list_q[i] <= PTR_W'(i);
            end
        end else if (!ovf_now) begin
            for (int unsigned j = 0; j < FREE_WAYS; j++) begin
                if (free_vld[j]) begin
                    list_q[wr_idx[j]] <= free_pr[j*PTR_W +: PTR_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= CW'(NUM_ARCH);
            tail_q <= CW'(NUM_PR);
            cnt_q  <= CW'(NUM_PR - NUM_ARCH);
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign alloc_gnt    = gnt;
    assign head_ptr     = head_q;
    assign free_cnt     = cnt_q;
    assign empty        = (cnt_q == '0);
    assign low          = (WW'(cnt_q) < WW'(ALLOC_WAYS));
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_free_list_param.sv
// Scoreboard bench for free_list_param: a pointer/array reference model predicts each
// cycle's outputs, and an independent monitor compares them against the DUT.
module tb_free_list_param;

    localparam int NUM_PR = 64;
    localparam int NUM_ARCH = 16;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int PW = 6;
    localparam int CW = 7;
    localparam int CM = 127;

    logic              clk;
    logic              rst;
    logic              stall;
    logic [AW-1:0]     alloc_req;
    logic              alloc_gnt;
    logic [AW*PW-1:0]  alloc_pr;
    logic [FW-1:0]     free_vld;
    logic [FW*PW-1:0]  free_pr;
    logic              flush;
    logic [CW-1:0]     flush_ptr;
    logic [CW-1:0]     head_ptr;
    logic [CW-1:0]     free_cnt;
    logic              empty;
    logic              low;
    logic              overflow_err;

    free_list_param #(
        .NUM_PR(NUM_PR),
        .NUM_ARCH(NUM_ARCH),
        .ALLOC_WAYS(AW),
        .FREE_WAYS(FW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_pr(alloc_pr),
        .free_vld(free_vld), .free_pr(free_pr),
        .flush(flush), .flush_ptr(flush_ptr),
        .head_ptr(head_ptr), .free_cnt(free_cnt),
        .empty(empty), .low(low), .overflow_err(overflow_err)
    );

    typedef struct {
        bit              gnt;
        logic [AW*PW-1:0] pr;
        int              head;
        int              cnt;
        bit              empty;
        bit              low;
        bit              ovf;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: unbounded integer pointers into a circular array of PR numbers.
    int m_head, m_tail;
    int m_lst[NUM_PR];
    bit m_ovf;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_head = NUM_ARCH;
        m_tail = NUM_PR;
        m_ovf = 0;
        for (int i = 0; i < NUM_PR; i++) m_lst[i] = i;
    endtask

    task automatic step(input logic [AW-1:0] req, input logic [FW-1:0] fv,
                        input logic [FW*PW-1:0] fp, input bit stl, input bit fl,
                        input int ck, input bit rs);
        exp_t e;
        int cnt, n, m, ng, k;
        bit g;
        @(negedge clk);
        rst = rs; stall = stl; alloc_req = req; free_vld = fv; free_pr = fp;
        flush = fl; flush_ptr = CW'(ck & CM);
        cnt = (m_tail - m_head) & CM;
        n = $countones(req);
        g = !rs && !stl && !fl && n != 0 && n <= cnt;
        e.gnt = g;
        e.pr = '0;
        k = 0;
        for (int i = 0; i < AW; i++) begin
            if (req[i]) begin
                if (g) e.pr[i*PW +: PW] = PW'(m_lst[(m_head + k) % NUM_PR]);
                k++;
            end
        end
        e.head = m_head & CM;
        e.cnt = cnt;
        e.empty = (cnt == 0);
        e.low = (cnt < AW);
        e.ovf = m_ovf;
        sbq.push_back(e);
        if (rs) begin
            model_reset();
        end else begin
            m = $countones(fv);
            ng = g ? n : 0;
            if (cnt - ng + m > NUM_PR) begin
                m_ovf = 1;
            end else begin
                k = 0;
                for (int j = 0; j < FW; j++) begin
                    if (fv[j]) begin
                        m_lst[(m_tail + k) % NUM_PR] = int'(fp[j*PW +: PW]);
                        k++;
                    end
                end
                m_tail += m;
            end
            if (fl) m_head = ck;
            else m_head += ng;
        end
    endtask

    task automatic idle();
        step('0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step('0, '0, '0, 0, 0, 0, 1);
    endtask

    // Monitor: compares every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("alloc_gnt", int'(alloc_gnt), int'(e.gnt));
                for (int i = 0; i < AW; i++)
                    chk($sformatf("alloc_pr[%0d]", i), int'(alloc_pr[i*PW +: PW]),
                        int'(e.pr[i*PW +: PW]));
                chk("head_ptr", int'(head_ptr), e.head);
                chk("free_cnt", int'(free_cnt), e.cnt);
                chk("empty", int'(empty), int'(e.empty));
                chk("low", int'(low), int'(e.low));
                chk("overflow_err", int'(overflow_err), int'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] rq;
        logic [FW-1:0] fv;
        logic [FW*PW-1:0] fp;
        int cnt, lim, ck, wait_cyc;
        bit rs, stl, fl;

        rst = 1; stall = 0; alloc_req = '0; free_vld = '0; free_pr = '0;
        flush = 0; flush_ptr = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Partial-lane grant right after reset.
        step(4'b1011, '0, '0, 0, 0, 0, 0);
        #3;
        chk("t1_gnt", int'(alloc_gnt), 1);
        chk("t1_lane0", int'(alloc_pr[0 +: PW]), 16);
        chk("t1_lane1", int'(alloc_pr[PW +: PW]), 17);
        chk("t1_lane2", int'(alloc_pr[2*PW +: PW]), 0);
        chk("t1_lane3", int'(alloc_pr[3*PW +: PW]), 18);
        idle();
        #3;
        chk("t1_head", int'(head_ptr), 19);
        chk("t1_cnt", int'(free_cnt), 45);

        // Drain to empty, then a refused request.
        do_reset();
        repeat (12) step(4'hF, '0, '0, 0, 0, 0, 0);
        step(4'hF, '0, '0, 0, 0, 0, 0);
        #3;
        chk("t2_gnt_empty", int'(alloc_gnt), 0);
        chk("t2_cnt", int'(free_cnt), 0);
        chk("t2_empty", int'(empty), 1);
        chk("t2_head", int'(head_ptr), 64);

        // Frees at empty are not bypassed to the same-cycle request.
        step(4'b0001, 4'b0101, {6'd0, 6'd9, 6'd0, 6'd7}, 0, 0, 0, 0);
        #3;
        chk("t3_gnt_nobypass", int'(alloc_gnt), 0);
        step(4'b0001, '0, '0, 0, 0, 0, 0);
        #3;
        chk("t3_gnt", int'(alloc_gnt), 1);
        chk("t3_pr", int'(alloc_pr[0 +: PW]), 7);

        // Checkpoint restore.
        do_reset();
        repeat (3) step(4'hF, '0, '0, 0, 0, 0, 0);
        step(4'hF, '0, '0, 0, 1, 16, 0);
        #3;
        chk("t4_gnt_flush", int'(alloc_gnt), 0);
        idle();
        #3;
        chk("t4_head", int'(head_ptr), 16);
        chk("t4_cnt", int'(free_cnt), 48);

        // Fill to full, then overflow.
        do_reset();
        repeat (4) step('0, 4'hF, {6'd40, 6'd41, 6'd42, 6'd43}, 0, 0, 0, 0);
        step('0, 4'b0001, {18'd0, 6'd44}, 0, 0, 0, 0);
        idle();
        #3;
        chk("t5_ovf", int'(overflow_err), 1);
        chk("t5_cnt", int'(free_cnt), 64);

        // Stall blocks allocation only; then reset mid-run.
        do_reset();
        step(4'hF, 4'b0011, {12'd0, 6'd20, 6'd21}, 1, 0, 0, 0);
        #3;
        chk("t6_gnt_stall", int'(alloc_gnt), 0);
        idle();
        #3;
        chk("t6_head", int'(head_ptr), 16);
        chk("t6_cnt", int'(free_cnt), 50);
        step(4'h3, 4'h1, 24'd5, 0, 0, 0, 0);
        do_reset();
        idle();
        #3;
        chk("t6_rst_head", int'(head_ptr), 16);
        chk("t6_rst_cnt", int'(free_cnt), 48);
        chk("t6_rst_ovf", int'(overflow_err), 0);

        // Randomized traffic, alternating drain-heavy and fill-heavy phases.
        for (int c = 0; c < 1500; c++) begin
            rs  = ($urandom_range(0, 249) == 0);
            stl = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            if (((c / 200) % 2) == 0) begin
                rq = AW'($urandom);
                fv = FW'($urandom & $urandom);
            end else begin
                rq = AW'($urandom & $urandom);
                fv = FW'($urandom);
            end
            fp = (FW*PW)'($urandom);
            cnt = (m_tail - m_head) & CM;
            lim = NUM_PR - NUM_ARCH;
            if (lim > m_head) lim = m_head;
            if (lim > NUM_PR - cnt) lim = NUM_PR - cnt;
            if (lim < 0) lim = 0;
            ck = m_head - $urandom_range(0, lim);
            step(rq, fv, fp, stl, fl, ck, rs);
        end
        idle();

        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        #5;
        chk("scoreboard_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
